// File: rtl/bullet_slot_arbiter.sv
// Purpose: shares a pool of bullet slots between two tanks' fire requests, round-robin on ties.
// Latency: eligible request -> spawn_valid on the next cycle (IDLE->SPAWN); min 2 cycles between spawns.
// Backpressure: a pool-full, capped or cooling-down tank stalls in IDLE with armed kept; requests are never dropped.
//
// Ports:
//   Clk, Reset_n           clock, asynchronous active-low reset
//   frame_tick             1-cycle pulse per video frame (drives aging and cooldown)
//   fire_req[1:0]          level fire request, [0]=tank1, [1]=tank2
//   hit[NUM_SLOTS-1:0]     1-cycle retire pulse per slot from collision logic
//   spawn_valid/slot/owner 1-cycle spawn command to the bullet datapath
//   slot_active/slot_owner live-slot map and owner bit per slot
//   count_t1/count_t2      live bullets per tank
module bullet_slot_arbiter #(
    parameter int NUM_SLOTS    = 4,
    parameter int MAX_PER_TANK = 2,
    parameter int LIFETIME     = 240,
    parameter int COOLDOWN     = 15
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_tick,
    input  logic [1:0]           fire_req,
    input  logic [NUM_SLOTS-1:0] hit,
    output logic                 spawn_valid,
    output logic [2:0]           spawn_slot,
    output logic                 spawn_owner,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic [3:0]           count_t1,
    output logic [3:0]           count_t2
);

    localparam int AW = $clog2(LIFETIME + 1);

    typedef enum logic {IDLE, SPAWN} state_t;

    state_t         state_q, state_d;
    logic [1:0]     armed_q;
    logic [7:0]     cd_q [2];
    logic [AW-1:0]  age_q [NUM_SLOTS];
    logic           rr_last_q;
    logic           win_owner_q;
    logic [2:0]     win_slot_q;

    logic           any_free;
    logic [2:0]     free_idx;
    logic [1:0]     elig;
    logic           grant_owner;
    logic           spawn_now;

    // Live bullet counts are derived from the slot map, so they can never
    // drift from the actual set of occupied slots.
    always_comb begin
        count_t1 = 4'd0;
        count_t2 = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_active[i]) begin
                if (slot_owner[i]) count_t2 = count_t2 + 4'd1;
                else               count_t1 = count_t1 + 4'd1;
            end
        end
    end

    // Lowest free slot index: scan from the top so the lowest index wins last.
    always_comb begin
        any_free = 1'b0;
        free_idx = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                any_free = 1'b1;
                free_idx = 3'(i);
            end
        end
    end

    always_comb begin
        elig[0] = armed_q[0] & fire_req[0] & (cd_q[0] == 8'd0)
                & (int'(count_t1) < MAX_PER_TANK) & any_free;
        elig[1] = armed_q[1] & fire_req[1] & (cd_q[1] == 8'd0)
                & (int'(count_t2) < MAX_PER_TANK) & any_free;
        // On a tie the tank that did not win last time goes first.
        if (elig[0] && elig[1]) grant_owner = ~rr_last_q;
        else                    grant_owner = elig[1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|elig) state_d = SPAWN;
            SPAWN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign spawn_now   = (state_q == SPAWN);
    assign spawn_valid = spawn_now;
    assign spawn_slot  = win_slot_q;
    assign spawn_owner = win_owner_q;

    // FSM state plus the winner captured on IDLE->SPAWN; SPAWN trusts it blindly
    // because only SPAWN can occupy a slot, so the chosen slot stays free.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            win_owner_q <= 1'b0;
            win_slot_q  <= 3'd0;
            rr_last_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |elig) begin
                win_owner_q <= grant_owner;
                win_slot_q  <= free_idx;
            end
            if (spawn_now) rr_last_q <= win_owner_q;
        end
    end

    // Per-tank arming (one bullet per press) and frame-counted cooldown.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            armed_q <= 2'b11;
            for (int t = 0; t < 2; t++) cd_q[t] <= 8'd0;
        end else begin
            for (int t = 0; t < 2; t++) begin
                if (spawn_now && win_owner_q == 1'(t)) begin
                    armed_q[t] <= 1'b0;
                    cd_q[t]    <= 8'(COOLDOWN);
                end else begin
                    if (!fire_req[t]) armed_q[t] <= 1'b1;
                    if (frame_tick && cd_q[t] != 8'd0) cd_q[t] <= cd_q[t] - 8'd1;
                end
            end
        end
    end

    // Slot map: spawn beats hit and aging on the slot being loaded; otherwise
    // a hit or reaching LIFETIME frees a live slot exactly once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_active <= '0;
            slot_owner  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (spawn_now && win_slot_q == 3'(i)) begin
                    slot_active[i] <= 1'b1;
                    slot_owner[i]  <= win_owner_q;
                    age_q[i]       <= '0;
                end else if (slot_active[i]) begin
                    if (hit[i]) begin
                        slot_active[i] <= 1'b0;
                        age_q[i]       <= '0;
                    end else if (frame_tick) begin
                        if (age_q[i] == AW'(LIFETIME - 1)) begin
                            slot_active[i] <= 1'b0;
                            age_q[i]       <= '0;
                        end else begin
                            age_q[i] <= age_q[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Purpose: self-checking bench for bullet_slot_arbiter (table, directed corners, random vs model).
// Latency: checks outputs every cycle on the falling edge after the active edge.
// Backpressure: n/a (bench).
module tb_bullet_slot_arbiter;

    localparam int NS  = 4;
    localparam int MPT = 2;
    localparam int LT  = 6;
    localparam int CD  = 2;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          frame_tick;
    logic [1:0]    fire_req;
    logic [NS-1:0] hit;
    logic          spawn_valid;
    logic [2:0]    spawn_slot;
    logic          spawn_owner;
    logic [NS-1:0] slot_active;
    logic [NS-1:0] slot_owner;
    logic [3:0]    count_t1;
    logic [3:0]    count_t2;

    bullet_slot_arbiter #(
        .NUM_SLOTS(NS), .MAX_PER_TANK(MPT), .LIFETIME(LT), .COOLDOWN(CD)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .fire_req(fire_req),
        .hit(hit), .spawn_valid(spawn_valid), .spawn_slot(spawn_slot),
        .spawn_owner(spawn_owner), .slot_active(slot_active), .slot_owner(slot_owner),
        .count_t1(count_t1), .count_t2(count_t2)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;
    int spawns = 0;
    int last_slot = -1;
    int last_owner = -1;

    // Reference model: bullets as a list of slot records, a pending grant, per-tank state.
    bit m_act [NS];
    bit m_own [NS];
    int m_age [NS];
    int m_cd  [2];
    bit m_arm [2];
    int m_rr;
    bit m_pend;
    int m_ps;
    int m_po;

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_own[i] = 0; m_age[i] = 0;
        end
        for (int t = 0; t < 2; t++) begin
            m_cd[t] = 0; m_arm[t] = 1;
        end
        m_rr = 1; m_pend = 0; m_ps = 0; m_po = 0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_step();
        int cnt [2];
        int free_i;
        bit el [2];
        cnt[0] = 0; cnt[1] = 0; free_i = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            if (m_act[i]) cnt[m_own[i]]++;
            else free_i = i;
        end
        for (int t = 0; t < 2; t++)
            el[t] = m_arm[t] && fire_req[t] && m_cd[t] == 0 && cnt[t] < MPT && free_i >= 0;
        for (int i = 0; i < NS; i++) begin
            if (m_pend && m_ps == i) begin
                m_act[i] = 1; m_own[i] = m_po[0]; m_age[i] = 0;
            end else if (m_act[i]) begin
                if (hit[i]) m_act[i] = 0;
                else if (frame_tick) begin
                    m_age[i]++;
                    if (m_age[i] >= LT) begin m_act[i] = 0; m_age[i] = 0; end
                end
            end
        end
        for (int t = 0; t < 2; t++) begin
            if (!fire_req[t]) m_arm[t] = 1;
            if (frame_tick && m_cd[t] > 0) m_cd[t]--;
        end
        if (m_pend) begin
            m_arm[m_po] = 0; m_cd[m_po] = CD; m_rr = m_po; m_pend = 0;
        end else if (el[0] || el[1]) begin
            m_pend = 1;
            m_ps   = free_i;
            m_po   = (el[0] && el[1]) ? 1 - m_rr : (el[1] ? 1 : 0);
        end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [NS-1:0] ea, eo;
        int ec1, ec2;
        bit ok;
        ea = '0; eo = '0; ec1 = 0; ec2 = 0;
        for (int i = 0; i < NS; i++) begin
            ea[i] = m_act[i]; eo[i] = m_own[i] & m_act[i];
            if (m_act[i]) begin
                if (m_own[i]) ec2++; else ec1++;
            end
        end
        ok = (spawn_valid == m_pend) && (slot_active == ea) && ((slot_owner & ea) == eo)
          && (int'(count_t1) == ec1) && (int'(count_t2) == ec2);
        if (m_pend && (int'(spawn_slot) != m_ps || int'(spawn_owner) != m_po)) ok = 0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL model[%s] t=%0t: got sv=%0d slot=%0d own=%0d act=%b ownmap=%b c1=%0d c2=%0d, expected sv=%0d slot=%0d own=%0d act=%b ownmap=%b c1=%0d c2=%0d",
                     tag, $time, spawn_valid, spawn_slot, spawn_owner, slot_active, slot_owner & ea,
                     count_t1, count_t2, m_pend, m_ps, m_po, ea, eo, ec1, ec2);
        end
    endtask

    task automatic cycle(input logic [1:0] fr, input logic tk, input logic [NS-1:0] h, input string tag);
        fire_req = fr; frame_tick = tk; hit = h;
        model_step();
        @(posedge Clk);
        @(negedge Clk);
        compare_model(tag);
        if (spawn_valid) begin
            spawns++; last_slot = int'(spawn_slot); last_owner = int'(spawn_owner);
        end
    endtask

    task automatic do_reset();
        fire_req = 2'b00; frame_tick = 1'b0; hit = '0;
        Reset_n = 1'b0;
        #1;
        model_reset();
        chk("reset spawn_valid", int'(spawn_valid), 0);
        chk("reset slot_active", int'(slot_active), 0);
        chk("reset counts", int'(count_t1) + int'(count_t2), 0);
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;
        spawns = 0;
    endtask

    typedef struct {
        logic [1:0]    fr;
        logic          tk;
        logic [NS-1:0] h;
        logic          sv;
        int            slot;
        int            own;
        logic [NS-1:0] act;
        int            c1;
        int            c2;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] fr, input logic tk, input logic [NS-1:0] h,
                                input logic sv, input int slot, input int own,
                                input logic [NS-1:0] act, input int c1, input int c2);
        vec_t v;
        v.fr = fr; v.tk = tk; v.h = h; v.sv = sv; v.slot = slot; v.own = own;
        v.act = act; v.c1 = c1; v.c2 = c2;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        logic [1:0] fr_r;
        // Contention, cooldown, cap, hit retire, lifetime expiry (LT=6, CD=2).
        tbl[0]  = mk(2'b00, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
        tbl[1]  = mk(2'b11, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0); // tie: tank1 first
        tbl[2]  = mk(2'b11, 0, 4'b0000, 0, 0, 0, 4'b0001, 1, 0);
        tbl[3]  = mk(2'b11, 0, 4'b0000, 1, 1, 1, 4'b0001, 1, 0); // tank2, 2 cycles later
        tbl[4]  = mk(2'b11, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 1);
        tbl[5]  = mk(2'b11, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 1); // held: no repeat
        tbl[6]  = mk(2'b00, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 1);
        tbl[7]  = mk(2'b01, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 1); // cooldown blocks
        tbl[8]  = mk(2'b01, 1, 4'b0000, 0, 0, 0, 4'b0011, 1, 1);
        tbl[9]  = mk(2'b01, 1, 4'b0000, 0, 0, 0, 4'b0011, 1, 1);
        tbl[10] = mk(2'b01, 0, 4'b0000, 1, 2, 0, 4'b0011, 1, 1); // cooldown expired
        tbl[11] = mk(2'b01, 0, 4'b0000, 0, 0, 0, 4'b0111, 2, 1);
        tbl[12] = mk(2'b00, 0, 4'b0000, 0, 0, 0, 4'b0111, 2, 1);
        tbl[13] = mk(2'b01, 0, 4'b0000, 0, 0, 0, 4'b0111, 2, 1); // capped
        tbl[14] = mk(2'b00, 0, 4'b0001, 0, 0, 0, 4'b0110, 1, 1); // hit retires slot0
        tbl[15] = mk(2'b10, 1, 4'b0000, 1, 0, 1, 4'b0110, 1, 1); // lowest free = 0
        tbl[16] = mk(2'b10, 1, 4'b0000, 0, 0, 0, 4'b0111, 1, 2);
        tbl[17] = mk(2'b00, 1, 4'b0000, 0, 0, 0, 4'b0111, 1, 2);
        tbl[18] = mk(2'b00, 1, 4'b0000, 0, 0, 0, 4'b0101, 1, 1); // slot1 reaches LT
        Reset_n = 1'b1; fire_req = 2'b00; frame_tick = 1'b0; hit = '0;
        #1;

        do_reset();
        for (int r = 0; r < 19; r++) begin
            cycle(tbl[r].fr, tbl[r].tk, tbl[r].h, $sformatf("tbl%0d", r));
            chk($sformatf("tbl%0d spawn_valid", r), int'(spawn_valid), int'(tbl[r].sv));
            if (tbl[r].sv) begin
                chk($sformatf("tbl%0d spawn_slot", r), int'(spawn_slot), tbl[r].slot);
                chk($sformatf("tbl%0d spawn_owner", r), int'(spawn_owner), tbl[r].own);
            end
            chk($sformatf("tbl%0d slot_active", r), int'(slot_active), int'(tbl[r].act));
            chk($sformatf("tbl%0d count_t1", r), int'(count_t1), tbl[r].c1);
            chk($sformatf("tbl%0d count_t2", r), int'(count_t2), tbl[r].c2);
        end

        // Cap: three tank1 presses, third stalls until slot0 is hit.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) cycle(2'b01, 0, '0, "cap press");
            for (int k = 0; k < 2; k++) cycle(2'b00, 1, '0, "cap release");
        end
        chk("cap two spawns", spawns, 2);
        for (int k = 0; k < 4; k++) cycle(2'b01, 0, '0, "cap stall");
        chk("cap third stalls", spawns, 2);
        cycle(2'b01, 0, 4'b0001, "cap hit");
        cycle(2'b01, 0, '0, "cap regrant");
        chk("cap third spawn_valid", int'(spawn_valid), 1);
        chk("cap third slot", last_slot, 0);
        chk("cap third owner", last_owner, 0);

        // Reset while in SPAWN: spawn aborted, nothing recorded, armed restored.
        do_reset();
        cycle(2'b01, 0, '0, "rst spawn");
        chk("rst in spawn", int'(spawn_valid), 1);
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst drops spawn_valid", int'(spawn_valid), 0);
        chk("rst no bullet", int'(slot_active), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        cycle(2'b00, 0, '0, "rst idle");
        chk("rst slots free", int'(slot_active), 0);
        cycle(2'b11, 0, '0, "rst rearm1");
        chk("rst tank1 first", int'(spawn_owner) + 2 * int'(spawn_valid), 2);
        cycle(2'b11, 0, '0, "rst rearm2");
        cycle(2'b11, 0, '0, "rst rearm3");
        chk("rst tank2 armed", int'(spawn_owner) + 2 * int'(spawn_valid), 3);

        // Random traffic against the model.
        do_reset();
        fr_r = 2'b00;
        for (int n = 0; n < 2500; n++) begin
            logic [NS-1:0] h;
            for (int t = 0; t < 2; t++)
                if ($urandom_range(0, 5) == 0) fr_r[t] = ~fr_r[t];
            for (int i = 0; i < NS; i++) h[i] = ($urandom_range(0, 11) == 0);
            cycle(fr_r, ($urandom_range(0, 4) == 0), h, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
